microcode_sequencer: RTL and testbench

//  Steps the microcode ROM for multi-uop x86 instructions. Sits between decode and the uop

---
 rtl/microcode_sequencer.sv | 108 ++++++++++
 tb/tb_microcode_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: steps ROM addresses {sel, step} for multi-uop
// instructions, passes non-ROM instructions through as a single uop.
module microcode_sequencer #(
  parameter int SEL_W     = 4,
  parameter int STEP_W    = 3,
  parameter int MAX_STEPS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    rom_in_control,
  input  logic [SEL_W-1:0]        rom_control,
  output logic [SEL_W+STEP_W-1:0] rom_addr,
  input  logic                    rom_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_from_rom,
  output logic [STEP_W-1:0]       out_step,
  input  logic                    flush,
  output logic                    seq_err,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    SEQ  = 2'd2
  } state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  state_t              state, state_nx;
  logic [SEL_W-1:0]    sel_q, sel_nx;
  logic [STEP_W-1:0]   step_q, step_nx;
  logic                err_nx;

  // State, entry select, step counter and error pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sel_q   <= '0;
      step_q  <= '0;
      seq_err <= 1'b0;
    end else begin
      state   <= state_nx;
      sel_q   <= sel_nx;
      step_q  <= step_nx;
      seq_err <= err_nx;
    end
  end

  // Next-state logic; flush overrides every other input
  always_comb begin
    state_nx = state;
    sel_nx   = sel_q;
    step_nx  = step_q;
    err_nx   = 1'b0;
    if (flush) begin
      state_nx = IDLE;
      step_nx  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (rom_in_control) begin
              state_nx = SEQ;
              sel_nx   = rom_control;
              step_nx  = '0;
            end else begin
              state_nx = PASS;
            end
          end
        end
        PASS: begin
          if (out_ready) state_nx = IDLE;
        end
        SEQ: begin
          if (out_ready) begin
            // cap is checked before incrementing so step_q never wraps
            if (rom_last) begin
              state_nx = IDLE;
              step_nx  = '0;
            end else if (step_q == LAST_STEP) begin
              state_nx = IDLE;
              step_nx  = '0;
              err_nx   = 1'b1;
            end else begin
              step_nx = step_q + 1'b1;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          step_nx  = '0;
        end
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state != IDLE);
  assign busy         = (state != IDLE);
  assign out_from_rom = (state == SEQ);
  assign out_step     = (state == SEQ) ? step_q : '0;
  assign rom_addr     = {sel_q, step_q};

endmodule

// File: tb/tb_microcode_sequencer.sv
// Randomized bench for microcode_sequencer against a uop-queue reference model.
module tb_microcode_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, rom_in_control, rom_last;
  logic [3:0] rom_control;
  logic [6:0] rom_addr;
  logic       out_valid, out_ready, out_from_rom, flush, seq_err, busy;
  logic [2:0] out_step;

  int n_tests = 0;
  int n_fail  = 0;

  // ROM model: sequence length per entry select, 0 = rom_last never set
  logic [3:0] rom_len [16];

  typedef struct {
    logic       from_rom;
    logic [6:0] addr;
    logic [2:0] step;
    logic       err;
  } uop_t;

  uop_t uop_q[$];
  logic m_err = 1'b0;

  always #5 clk = ~clk;

  assign rom_last = (rom_len[rom_addr[6:3]] != 4'd0) &&
                    ({1'b0, rom_addr[2:0]} == rom_len[rom_addr[6:3]] - 4'd1);

  microcode_sequencer #(.SEL_W(4), .STEP_W(3), .MAX_STEPS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .rom_in_control (rom_in_control),
    .rom_control    (rom_control),
    .rom_addr       (rom_addr),
    .rom_last       (rom_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_from_rom   (out_from_rom),
    .out_step       (out_step),
    .flush          (flush),
    .seq_err        (seq_err),
    .busy           (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic empty;
    empty = (uop_q.size() == 0);
    check_eq("in_ready", 32'(in_ready), 32'(empty));
    check_eq("out_valid", 32'(out_valid), 32'(!empty));
    check_eq("busy", 32'(busy), 32'(!empty));
    check_eq("seq_err", 32'(seq_err), 32'(m_err));
    if (!empty) begin
      check_eq("out_from_rom", 32'(out_from_rom), 32'(uop_q[0].from_rom));
      if (uop_q[0].from_rom) begin
        check_eq("rom_addr", 32'(rom_addr), 32'(uop_q[0].addr));
        check_eq("out_step", 32'(out_step), 32'(uop_q[0].step));
      end
    end
  endtask

  // Expand an accepted instruction into the full list of uops it must produce
  task automatic push_instr(input logic ric, input logic [3:0] sel);
    uop_t u;
    int   n;
    bit   capped;
    if (!ric) begin
      u.from_rom = 1'b0; u.addr = '0; u.step = '0; u.err = 1'b0;
      uop_q.push_back(u);
    end else begin
      capped = (rom_len[sel] == 4'd0) || (rom_len[sel] > 4'd8);
      n = capped ? 8 : int'(rom_len[sel]);
      for (int i = 0; i < n; i++) begin
        u.from_rom = 1'b1;
        u.addr     = {sel, 3'(i)};
        u.step     = 3'(i);
        u.err      = capped && (i == n - 1);
        uop_q.push_back(u);
      end
    end
  endtask

  task automatic step_cycle(input logic iv, input logic ric, input logic [3:0] rc,
                            input logic ordy, input logic fl);
    uop_t u;
    @(negedge clk);
    compare_outputs();
    in_valid = iv; rom_in_control = ric; rom_control = rc; out_ready = ordy; flush = fl;
    @(posedge clk);
    m_err = 1'b0;
    if (fl) uop_q.delete();
    else if (uop_q.size() == 0) begin
      if (iv) push_instr(ric, rc);
    end else if (ordy) begin
      u = uop_q.pop_front();
      if (u.err) m_err = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; rom_in_control = 1'b0; rom_control = '0; out_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_len[i] = 4'd0;
    rom_len[5] = 4'd3;
    rom_len[3] = 4'd0;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_out_step", 32'(out_step), 32'd0);
    check_eq("rst_from_rom", 32'(out_from_rom), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_seq_err", 32'(seq_err), 32'd0);
    reset = 1'b1;

    // pass-through
    step_cycle(1, 0, 4'h0, 1, 0);
    step_cycle(0, 0, 4'h0, 1, 0);
    step_cycle(0, 0, 4'h0, 0, 0);
    // 3-uop sequence 0x28..0x2A
    step_cycle(1, 1, 4'h5, 1, 0);
    repeat (4) step_cycle(0, 0, 4'h0, 1, 0);
    // same sequence with a 2-cycle stall at step 1
    step_cycle(1, 1, 4'h5, 1, 0);
    step_cycle(0, 0, 4'h0, 1, 0);
    step_cycle(1, 1, 4'h9, 0, 0);
    step_cycle(0, 0, 4'h0, 0, 0);
    repeat (3) step_cycle(0, 0, 4'h0, 1, 0);
    // cap: 8 uops 0x18..0x1F then seq_err pulse
    step_cycle(1, 1, 4'h3, 1, 0);
    repeat (10) step_cycle(0, 0, 4'h0, 1, 0);
    // flush at step 1 with in_valid and out_ready high
    step_cycle(1, 1, 4'h5, 1, 0);
    step_cycle(0, 0, 4'h0, 1, 0);
    step_cycle(1, 1, 4'h7, 1, 1);
    step_cycle(0, 0, 4'h0, 0, 0);
    step_cycle(0, 0, 4'h0, 0, 0);

    // reset mid-sequence: outputs return to reset values without a clock edge
    step_cycle(1, 1, 4'h3, 1, 0);
    step_cycle(0, 0, 4'h0, 1, 0);
    step_cycle(0, 0, 4'h0, 0, 0);
    @(negedge clk);
    compare_outputs();
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    uop_q.delete();
    m_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // random traffic with randomized ROM sequence lengths
    for (int i = 0; i < 16; i++) rom_len[i] = 4'($urandom_range(0, 8));
    for (int c = 0; c < 600; c++) begin
      step_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0);
    end
    step_cycle(0, 0, 4'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
